stopwatch_core: RTL
===================

// Module: stopwatch_core
// PURPOSE
//  Parametrised stopwatch timebase and BCD counter with start/stop, clear and lap-hold control.
//  Divides clk down to a TICK_HZ count enable and advances a chain of NUM_DIGITS BCD digits.
//  Sits between the button debouncers and the seven-segment display multiplexer.
//  Adds lap freeze, configurable wrap or saturate, and per-digit modulus to the original counter.
// PARAMETERS
//  CLK_HZ      100_000_000  input clock frequency
//  TICK_HZ     100          count rate (LSD period = 1/TICK_HZ s)
//  NUM_DIGITS  4            BCD digits in chain, 1..8; digit 0 is LSD
//  MOD6_MASK   4'b1000      bit i set -> digit i counts 0..5 instead of 0..9 (width NUM_DIGITS)
//  WRAP        1            1: all-max rolls to zero and pulses overflow; 0: saturate and stop
// PORTS
//  clk         in   1              system clock
//  reset       in   1              asynchronous, active-low reset
//  start_stop  in   1              debounced level; rising edge toggles run/pause
//  clear       in   1              debounced level; rising edge zeroes count, stops, releases lap
//  lap         in   1              debounced level; rising edge toggles display hold
//  digits      out  4*NUM_DIGITS   displayed BCD, digit i at [4i+3:4i]
//  running     out  1              1 while counting
//  lap_held    out  1              1 while digits is frozen
//  tick        out  1              1-cycle pulse each count advance
//  overflow    out  1              WRAP=1: 1-cycle pulse on rollover; WRAP=0: level while saturated
// BEHAVIOUR
//  Reset (reset=0, async): all outputs 0, count 0, prescaler 0, edge-detect regs 0, state IDLE.
//  Edge detect: each input registered once; edge = in & ~in_q. Action visible 1 cycle after the
//   sampled rising edge. Held-high inputs act once only.
//  DIV = CLK_HZ/TICK_HZ (integer, >=2); prescaler width $clog2(DIV).
//  FSM states:
//   IDLE: count 0, running=0. start_stop edge -> RUN, prescaler cleared.
//   RUN: running=1. Prescaler counts 0..DIV-1. At DIV-1: prescaler <- 0, tick=1, count increments.
//    start_stop edge -> PAUSE.
//   PAUSE: running=0. Prescaler and count hold. start_stop edge -> RUN; prescaler resumes from held value.
//   SAT (WRAP=0 only): entered when count at all-max would increment. Count holds all-max,
//    running=0, overflow=1. start_stop is ignored here; only clear leaves.
//  Increment: digit 0 +1; a digit at its max (9, or 5 if MOD6_MASK[i]) -> 0 and carries to i+1.
//   Top-digit carry: WRAP=1 -> all 0, overflow pulse in the same cycle as tick; WRAP=0 -> SAT.
//  Lap: rising edge in RUN or PAUSE with lap_held=0 -> lap_held=1, and digits latch the
//   current count (value after any same-cycle increment). Rising edge with lap_held=1 -> lap_held=0,
//   and digits follow the live count again. Ignored in IDLE. Count keeps advancing underneath the hold.
//  digits = lap_held ? lap register : live count. The output is registered.
//  clear edge (any state): count, prescaler and lap are zeroed, lap_held=0, overflow=0, state IDLE.
//  Priority in the same cycle: clear > start_stop > lap.
//   A tick coincident with a pause edge still applies its increment.
//  Reset asserted mid-count returns to IDLE/zero immediately. No tick is issued on release.
// TESTING
//  Bench params: CLK_HZ=1000, TICK_HZ=100 -> DIV=10; NUM_DIGITS=4; MOD6_MASK=4'b1000.
//  1 Start from IDLE, run 125 clks -> 12 ticks, digits=0x0012, running=1; first tick 10 clks after start.
//  2 Pause at count 0x0007, idle 50 clks -> digits stays 0x0007, no tick.
//    Resume -> next tick after the remaining prescaler cycles (not a full 10).
//  3 WRAP=1, preload by running to 0x5999 -> next tick gives 0x0000, overflow 1-cycle pulse with tick.
//    WRAP=0 same -> digits 0x5999, overflow=1, running=0; start_stop ignored; clear -> 0, IDLE.
//  4 Lap at 0x0034 -> digits frozen 0x0034 while 30 more ticks run.
//    Second lap -> digits=0x0064, lap_held=0.
//  5 clear, start_stop and lap rising in the same cycle while RUN -> IDLE, digits 0, lap_held 0.
//    start_stop held high 100 clks -> single toggle only.
//  6 Assert reset mid-RUN at 0x0120 -> all outputs 0 asynchronously.
//    Release -> stays IDLE, no tick until start_stop.

Source files
------------

// File: rtl/stopwatch_core.sv
// stopwatch_core: prescaled BCD stopwatch with start/stop, clear, lap hold and wrap/saturate overflow
module stopwatch_core #(
  parameter int                    CLK_HZ     = 100_000_000,
  parameter int                    TICK_HZ    = 100,
  parameter int                    NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS-1:0] MOD6_MASK  = 4'b1000,
  parameter bit                    WRAP       = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop,
  input  logic                    clear,
  input  logic                    lap,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    lap_held,
  output logic                    tick,
  output logic                    overflow
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam int CW  = 4 * NUM_DIGITS;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, SAT} state_t;
  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [CW-1:0]   cnt_q, cnt_d, hold_q, hold_d, digits_q, digits_d, cnt_inc;
  logic            lap_held_q, lap_held_d, tick_q, tick_d, overflow_q, overflow_d;
  logic            running_q, running_d;
  logic            start_stop_q, clear_q, lap_q;
  logic            ss_e, clr_e, lap_e, pre_end, all_max, wrap_ovf;
  assign ss_e    = start_stop & ~start_stop_q;
  assign clr_e   = clear & ~clear_q;
  assign lap_e   = lap & ~lap_q;
  assign pre_end = pre_q == PW'(DIV - 1);
  assign digits   = digits_q;
  assign running  = running_q;
  assign lap_held = lap_held_q;
  assign tick     = tick_q;
  assign overflow = overflow_q;
  // BCD ripple increment; all_max is the carry out of the top digit
  always_comb begin
    cnt_inc = cnt_q;
    all_max = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (all_max) begin
        if (cnt_q[4*i +: 4] == (MOD6_MASK[i] ? 4'd5 : 4'd9)) cnt_inc[4*i +: 4] = 4'd0;
        else begin
          cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
          all_max = 1'b0;
        end
      end
    end
  end
  // FSM next state, prescaler, count, lap hold and registered outputs; clear overrides all
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    lap_held_d = lap_held_q;
    tick_d     = 1'b0;
    wrap_ovf   = 1'b0;
    case (state_q)
      IDLE: if (ss_e) begin
        state_d = RUN;
        pre_d   = '0;
      end
      RUN: begin
        pre_d = pre_end ? '0 : pre_q + PW'(1);
        if (pre_end && all_max && !WRAP) state_d = SAT;
        else if (pre_end) begin
          cnt_d    = cnt_inc;
          tick_d   = 1'b1;
          wrap_ovf = all_max;
        end
        if (ss_e && state_d == RUN) state_d = PAUSE;
      end
      PAUSE: if (ss_e) state_d = RUN;
      default: ;
    endcase
    if (lap_e && (state_q == RUN || state_q == PAUSE)) begin
      lap_held_d = ~lap_held_q;
      if (!lap_held_q) hold_d = cnt_d;
    end
    if (clr_e) begin
      state_d    = IDLE;
      pre_d      = '0;
      cnt_d      = '0;
      hold_d     = '0;
      lap_held_d = 1'b0;
      tick_d     = 1'b0;
      wrap_ovf   = 1'b0;
    end
    overflow_d = wrap_ovf | (state_d == SAT);
    running_d  = state_d == RUN;
    digits_d   = lap_held_d ? hold_d : cnt_d;
  end
  // state, datapath and input edge-detect registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      lap_held_q   <= 1'b0;
      tick_q       <= 1'b0;
      overflow_q   <= 1'b0;
      running_q    <= 1'b0;
      digits_q     <= '0;
      start_stop_q <= 1'b0;
      clear_q      <= 1'b0;
      lap_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      lap_held_q   <= lap_held_d;
      tick_q       <= tick_d;
      overflow_q   <= overflow_d;
      running_q    <= running_d;
      digits_q     <= digits_d;
      start_stop_q <= start_stop;
      clear_q      <= clear;
      lap_q        <= lap;
    end
  end
endmodule
